port_io_host: RTL and testbench

PORT_IO_HOST -- requirements
Module: port_io_host

---
 rtl/port_io_pkg.sv | 44 ++++
 rtl/port_io_host_seq.sv | 41 ++++
 rtl/port_io_host.sv | 150 +++++++++++++++
 tb/tb_port_io_host.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/port_io_pkg.sv
// Shared definitions for the port I/O host: slot types, register map, frame geometry.
package port_io_pkg;

  typedef enum logic [2:0] {
    SLOT_IDLE  = 3'd0,
    SLOT_DIR   = 3'd1,
    SLOT_READ  = 3'd2,
    SLOT_WRITE = 3'd3,
    SLOT_LAST  = 3'd4
  } slot_type_e;

  localparam logic [4:0] ADDR_DIR_BASE = 5'd0;
  localparam logic [4:0] ADDR_OUT_BASE = 5'd8;
  localparam logic [4:0] ADDR_IN_BASE  = 5'd16;
  localparam logic [4:0] ADDR_STATUS   = 5'd24;

  function automatic int frame_len(input int nports);
    return 3 * nports + 2;
  endfunction

  // Slots 1.. repeat DIR/READ/WRITE per port between the IDLE and LAST slots.
  function automatic slot_type_e decode_slot(input logic [4:0] slot, input logic [4:0] last_slot);
    logic [4:0] rel;
    rel = slot - 5'd1;
    if (slot == 5'd0) begin
      return SLOT_IDLE;
    end else if (slot == last_slot) begin
      return SLOT_LAST;
    end else begin
      case (rel % 5'd3)
        5'd0:    return SLOT_DIR;
        5'd1:    return SLOT_READ;
        default: return SLOT_WRITE;
      endcase
    end
  endfunction

  function automatic logic [2:0] decode_port(input logic [4:0] slot);
    logic [4:0] rel;
    rel = slot - 5'd1;
    return 3'(rel / 5'd3);
  endfunction

endpackage

// File: rtl/port_io_host_seq.sv
// Frame slot sequencer: slot counter, current/next slot decode and frame_done pulse.
module port_io_host_seq
  import port_io_pkg::*;
#(
  parameter int NPORTS = 3
) (
  input  logic       clk,
  input  logic       rst,
  output slot_type_e o_cur_type,
  output logic [2:0] o_cur_port,
  output slot_type_e o_nxt_type,
  output logic [2:0] o_nxt_port,
  output logic       o_frame_done
);

  localparam logic [4:0] LAST_SLOT = 5'(frame_len(NPORTS) - 1);

  logic [4:0] r_slot;
  logic [4:0] w_slot_nxt;
  logic       r_frame_done;

  assign w_slot_nxt = (r_slot == LAST_SLOT) ? 5'd0 : r_slot + 5'd1;

  // frame_done is registered from the next slot so it is high exactly during LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot       <= 5'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_slot       <= w_slot_nxt;
      r_frame_done <= (w_slot_nxt == LAST_SLOT);
    end
  end

  assign o_cur_type   = decode_slot(r_slot, LAST_SLOT);
  assign o_cur_port   = decode_port(r_slot);
  assign o_nxt_type   = decode_slot(w_slot_nxt, LAST_SLOT);
  assign o_nxt_port   = decode_port(w_slot_nxt);
  assign o_frame_done = r_frame_done;

endmodule

// File: rtl/port_io_host.sv
// Host side of a time-multiplexed port bus: CPU register file, staging/commit, and bus drive.
module port_io_host
  import port_io_pkg::*;
#(
  parameter int NPORTS = 3
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] data,
  input  logic [4:0] cpu_addr,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_rd,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  output logic       frame_done
);

  localparam logic [1:0] REG_DIR = ADDR_DIR_BASE[4:3];
  localparam logic [1:0] REG_OUT = ADDR_OUT_BASE[4:3];
  localparam logic [1:0] REG_IN  = ADDR_IN_BASE[4:3];

  slot_type_e w_cur_type;
  slot_type_e w_nxt_type;
  logic [2:0] w_cur_port;
  logic [2:0] w_nxt_port;

  logic [7:0] r_dir_stg [8];
  logic [7:0] r_out_stg [8];
  logic [7:0] r_dir_act [8];
  logic [7:0] r_out_act [8];
  logic [7:0] r_in      [8];
  logic [7:0] r_frame_cnt;
  logic [7:0] r_dout;
  logic       r_oe;
  logic [7:0] r_rdata;
  logic       r_rvalid;

  logic [2:0] w_idx;
  logic [1:0] w_region;
  logic       w_idx_ok;
  logic       w_commit;
  logic [7:0] w_rd_val;

  port_io_host_seq #(.NPORTS(NPORTS)) u_seq (
    .clk          (clk),
    .rst          (rst),
    .o_cur_type   (w_cur_type),
    .o_cur_port   (w_cur_port),
    .o_nxt_type   (w_nxt_type),
    .o_nxt_port   (w_nxt_port),
    .o_frame_done (frame_done)
  );

  assign w_idx    = cpu_addr[2:0];
  assign w_region = cpu_addr[4:3];
  assign w_idx_ok = (int'(w_idx) < NPORTS);
  // The edge leaving LAST is the edge entering slot 0.
  assign w_commit = (w_cur_type == SLOT_LAST);

  // Register file: CPU writes into staging, frame commit, IN capture, frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_dir_stg[i] <= 8'h00;
        r_out_stg[i] <= 8'h00;
        r_dir_act[i] <= 8'h00;
        r_out_act[i] <= 8'h00;
        r_in[i]      <= 8'h00;
      end
      r_frame_cnt <= 8'h00;
    end else begin
      if (w_commit) begin
        for (int i = 0; i < NPORTS; i++) begin
          r_dir_act[i] <= r_dir_stg[i];
          r_out_act[i] <= r_out_stg[i];
        end
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      if (cpu_wr && w_idx_ok) begin
        case (w_region)
          REG_DIR: r_dir_stg[w_idx] <= cpu_wdata;
          REG_OUT: r_out_stg[w_idx] <= cpu_wdata;
          default: ;
        endcase
      end
      if (w_cur_type == SLOT_READ) begin
        r_in[w_cur_port] <= data;
      end
    end
  end

  // Read mux sees pre-edge state, so same-cycle writes and IN captures return old values.
  always_comb begin
    w_rd_val = 8'h00;
    if (cpu_addr == ADDR_STATUS) begin
      w_rd_val = r_frame_cnt;
    end else if (w_idx_ok) begin
      case (w_region)
        REG_DIR: w_rd_val = r_dir_stg[w_idx];
        REG_OUT: w_rd_val = r_out_stg[w_idx];
        REG_IN:  w_rd_val = r_in[w_idx];
        default: w_rd_val = 8'h00;
      endcase
    end else begin
      w_rd_val = 8'h00;
    end
  end

  // Registered read response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= 8'h00;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= cpu_rd;
      if (cpu_rd) begin
        r_rdata <= w_rd_val;
      end
    end
  end

  // Bus drive registered from the next-slot decode so it changes only on slot boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_oe   <= 1'b0;
      r_dout <= 8'h00;
    end else begin
      case (w_nxt_type)
        SLOT_DIR: begin
          r_oe   <= 1'b1;
          r_dout <= r_dir_act[w_nxt_port];
        end
        SLOT_WRITE: begin
          r_oe   <= 1'b1;
          r_dout <= r_out_act[w_nxt_port];
        end
        default: begin
          r_oe   <= 1'b0;
          r_dout <= 8'h00;
        end
      endcase
    end
  end

  assign data       = r_oe ? r_dout : 8'hzz;
  assign cpu_rdata  = r_rdata;
  assign cpu_rvalid = r_rvalid;

endmodule

// File: tb/tb_port_io_host.sv
// Self-checking bench for port_io_host: slot-aware device model plus a read scoreboard.
module tb_port_io_host;

  localparam int NP = 3;
  localparam int LAST = 3 * NP + 1;
  // Weak pull-ups make a released bus read as all ones.
  localparam logic [7:0] BUS_REL = 8'hFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] cpu_addr = 5'd0;
  logic       cpu_wr = 1'b0;
  logic [7:0] cpu_wdata = 8'h00;
  logic       cpu_rd = 1'b0;
  logic [7:0] cpu_rdata;
  logic       cpu_rvalid;
  logic       frame_done;
  wire  [7:0] data;

  logic [7:0] dev_val [NP];
  logic       dev_oe;
  logic [7:0] dev_bus;
  int         tb_slot = 0;
  int         m_frames = 0;
  bit         mon_en = 1'b0;
  logic       prev_rd = 1'b0;
  logic [7:0] rd_q [$];
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  for (genvar b = 0; b < 8; b++) begin : g_pull
    pullup (data[b]);
  end

  port_io_host #(.NPORTS(NP)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .cpu_addr   (cpu_addr),
    .cpu_wr     (cpu_wr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rd     (cpu_rd),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .frame_done (frame_done)
  );

  // Port-side device: follows its own slot counter and drives IN data in READ slots.
  always_comb begin
    dev_oe  = 1'b0;
    dev_bus = 8'h00;
    if (tb_slot >= 1 && tb_slot < LAST && (tb_slot - 1) % 3 == 1) begin
      dev_oe  = 1'b1;
      dev_bus = dev_val[(tb_slot - 1) / 3];
    end
  end
  assign data = dev_oe ? dev_bus : 8'hzz;

  always @(posedge clk) begin
    if (rst) begin
      tb_slot  <= 0;
      m_frames <= 0;
    end else begin
      tb_slot <= (tb_slot == LAST) ? 0 : tb_slot + 1;
      if (tb_slot == LAST) m_frames <= m_frames + 1;
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t slot=%0d)", tag, got, exp, $time, tb_slot);
    end
  endtask

  // Every-cycle checks: frame_done alignment, bus release, read latency and scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("frame_done", 8'(frame_done), 8'(tb_slot == LAST));
      if (tb_slot == 0 || tb_slot == LAST) check("bus_release", data, BUS_REL);
      if (dev_oe) check("bus_read_slot", data, dev_bus);
      if (cpu_rvalid || prev_rd) check("rvalid_latency", 8'(cpu_rvalid), 8'(prev_rd));
      if (cpu_rvalid && rd_q.size() > 0) check("rdata", cpu_rdata, rd_q.pop_front());
    end
    prev_rd <= cpu_rd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_slot(input int s);
    int n;
    n = 0;
    while (tb_slot != s && n < 4 * LAST) begin
      tick();
      n++;
    end
    if (tb_slot != s) check("wait_slot_timeout", 8'(tb_slot), 8'(s));
  endtask

  task automatic wait_frame_slot(input int f, input int s);
    int n;
    n = 0;
    while (!(m_frames == f && tb_slot == s) && n < 4000) begin
      tick();
      n++;
    end
    if (m_frames != f) check("wait_frame_timeout", 8'(m_frames), 8'(f));
  endtask

  task automatic bus_at(input string tag, input int s, input logic [7:0] exp);
    wait_slot(s);
    @(negedge clk);
    check(tag, data, exp);
    tick();
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    tick();
    cpu_wr    = 1'b0;
  endtask

  task automatic cpu_read(input logic [4:0] a, input logic [7:0] exp);
    cpu_addr = a;
    cpu_rd   = 1'b1;
    rd_q.push_back(exp);
    tick();
    cpu_rd   = 1'b0;
  endtask

  task automatic cpu_rdwr(input logic [4:0] a, input logic [7:0] d, input logic [7:0] exp);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    cpu_rd    = 1'b1;
    rd_q.push_back(exp);
    tick();
    cpu_wr    = 1'b0;
    cpu_rd    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dev_val[0] = 8'h11;
    dev_val[1] = 8'h22;
    dev_val[2] = 8'h3C;
    repeat (3) tick();
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_rdata", cpu_rdata, 8'h00);
    check("rst_rvalid", 8'(cpu_rvalid), 8'h00);
    tick();
    rst = 1'b0;

    cpu_read(5'd18, 8'h00);
    cpu_read(5'd24, 8'h00);

    wait_slot(2);
    cpu_write(5'd1, 8'hFF);
    cpu_write(5'd9, 8'hA5);
    bus_at("dir1_same_frame", 4, 8'h00);
    bus_at("out1_same_frame", 6, 8'h00);
    bus_at("dir1_next_frame", 4, 8'hFF);
    bus_at("out1_next_frame", 6, 8'hA5);
    cpu_read(5'd1, 8'hFF);
    cpu_read(5'd9, 8'hA5);
    cpu_read(5'd18, 8'h3C);

    dev_val[2] = 8'h5A;
    wait_slot(8);
    cpu_read(5'd18, 8'h3C);
    cpu_read(5'd18, 8'h5A);

    wait_slot(LAST);
    cpu_write(5'd0, 8'h55);
    bus_at("dir0_one_frame", 1, 8'h00);
    bus_at("dir0_two_frames", 1, 8'h55);

    wait_slot(5);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cpu_read(5'd1, 8'h00);
    cpu_read(5'd9, 8'h00);
    cpu_read(5'd0, 8'h00);
    cpu_read(5'd18, 8'h00);
    cpu_read(5'd24, 8'h00);
    cpu_rdwr(5'd8, 8'h77, 8'h00);
    cpu_read(5'd8, 8'h77);
    cpu_write(5'd24, 8'h99);
    bus_at("dir1_after_rst", 4, 8'h00);

    wait_frame_slot(2, 5);
    cpu_read(5'd24, 8'h02);
    wait_frame_slot(255, 5);
    cpu_read(5'd24, 8'hFF);
    wait_frame_slot(256, 5);
    cpu_read(5'd24, 8'h00);
    cpu_read(5'd30, 8'h00);
    cpu_write(5'd16, 8'hEE);
    cpu_read(5'd16, 8'h11);

    repeat (3) tick();
    check("rd_queue_drained", 8'(rd_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
